// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and FSM state type for the IF stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  typedef enum logic [1:0] {REQ, WAIT, HAVE, DROP} fetchState_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats stall, idle cycles load a bubble.
module if_id_reg import fetch_pkg::*; #(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pcPlus4,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);
  // Bubbles keep PCD/PCPlus4D so decode still sees the last known PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (flush || (!stall && !load)) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!stall) begin
      InstrD   <= instr;
      PCD      <= pc;
      PCPlus4D <= pcPlus4;
      ValidD   <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with single-outstanding imem handshake and IF/ID register.
// Define FETCH_STATS_EN to add the bubble/redirect statistic counters.
module fetch_stage import fetch_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FetchBusy
`ifdef FETCH_STATS_EN
  ,
  output logic [XLEN-1:0] stat_bubble_cnt,
  output logic [XLEN-1:0] stat_redirect_cnt
`endif
);
  fetchState_t state, stateNext;
  logic [XLEN-1:0] pcF, fbuf, word;
  logic avail, advance;
  assign avail     = (state == HAVE) || (state == WAIT && imem_rvalid);
  assign advance   = avail && !StallF && !StallD && !PCSrcE;
  assign word      = (state == HAVE) ? fbuf : imem_rdata;
  assign FetchBusy = !avail;
  assign imem_req  = rst_n && (state == REQ);
  assign imem_addr = pcF;
  // A redirect with a request in flight must swallow the stale response in DROP.
  always_comb begin
    stateNext = state;
    case (state)
      REQ:     stateNext = imem_ready ? (PCSrcE ? DROP : WAIT) : REQ;
      WAIT:    stateNext = imem_rvalid ? ((PCSrcE || advance) ? REQ : HAVE) : (PCSrcE ? DROP : WAIT);
      HAVE:    stateNext = (PCSrcE || advance) ? REQ : HAVE;
      DROP:    stateNext = imem_rvalid ? REQ : DROP;
      default: stateNext = REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= REQ;
      pcF   <= RESET_PC;
      fbuf  <= '0;
    end else begin
      state <= stateNext;
      pcF   <= PCSrcE ? PCTargetE : advance ? pcF + 32'd4 : pcF;
      if (state == WAIT && imem_rvalid && !advance && !PCSrcE) fbuf <= imem_rdata;
    end
  end
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) ifId (
    .clk(clk), .rst_n(rst_n), .flush(FlushD), .stall(StallD), .load(advance),
    .instr(word), .pc(pcF), .pcPlus4(pcF + 32'd4),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bubble_cnt   <= '0;
      stat_redirect_cnt <= '0;
    end else begin
      if (!FlushD && !StallD && !advance) stat_bubble_cnt <= stat_bubble_cnt + 32'd1;
      if (PCSrcE) stat_redirect_cnt <= stat_redirect_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage with a latency-configurable memory model.
module tb_fetch_stage;
  logic clk = 0, rst_n = 0;
  logic StallF = 0, StallD = 0, FlushD = 0, PCSrcE = 0;
  logic [31:0] PCTargetE = 0;
  logic imem_req, imem_ready = 0, imem_rvalid = 0;
  logic [31:0] imem_addr, imem_rdata = 0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic ValidD, FetchBusy;
`ifdef FETCH_STATS_EN
  logic [31:0] statBubble, statRedirect, base;
`endif

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchBusy(FetchBusy)
`ifdef FETCH_STATS_EN
    , .stat_bubble_cnt(statBubble), .stat_redirect_cnt(statRedirect)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
  exp_t q[$];
  exp_t eM;
  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: one outstanding request, response lat cycles after the extra cycle, rdata=addr.
  logic memOn = 0, forceDead = 0, acceptFlag = 0, pending = 0;
  int lat = 0, cnt = 0;
  logic [31:0] pendAddr = 0;
  initial forever begin
    @(negedge clk); #1;
    imem_rvalid = 0;
    acceptFlag = 0;
    if (!rst_n) begin
      pending = 0;
      imem_ready = 0;
    end else begin
      if (pending) begin
        if (cnt == 0) begin
          imem_rvalid = 1;
          imem_rdata = forceDead ? 32'hDEAD : pendAddr;
          forceDead = 0;
          pending = 0;
        end else cnt--;
      end
      imem_ready = memOn;
      if (imem_req && imem_ready && !pending) begin
        pending = 1;
        pendAddr = imem_addr;
        cnt = lat;
        acceptFlag = 1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever IF/ID newly presents a valid instruction.
  int cyc = 0, lastPop = -1;
  logic rateChk = 0, heldM;
  initial forever begin
    @(posedge clk);
    cyc++;
    heldM = StallD && !FlushD;
    #1;
    if (rst_n && ValidD && !heldM) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected: got pc %h instr %h expected none", PCD, InstrD);
      end else begin
        eM = q.pop_front();
        check("InstrD", InstrD, eM.instr);
        check("PCD", PCD, eM.pc);
        check("PCPlus4D", PCPlus4D, eM.pc + 32'd4);
        if (rateChk && lastPop >= 0) check("rate", cyc - lastPop, 2);
        lastPop = cyc;
      end
    end
  end

  task automatic drain(input int maxc);
    int n = 0;
    while (q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    memOn = 0;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #2;
    check("rstReq", imem_req, 0);
    check("rstValid", ValidD, 0);
    check("rstInstr", InstrD, 32'h13);
    check("rstPCD", PCD, 0);
    for (int i = 0; i < 4; i++) q.push_back('{pc: 32'(4 * i), instr: 32'(4 * i)});
    rateChk = 1;
    memOn = 1;
    @(negedge clk);
    rst_n = 1;
    #2;
    check("relReq", imem_req, 1);
    check("relAddr", imem_addr, 0);
    drain(20);
    rateChk = 0;
    // Stall while the word for 0x10 returns: held in HAVE, released next edge.
    q.push_back('{pc: 32'h10, instr: 32'h10});
    StallF = 1; StallD = 1; memOn = 1;
    repeat (3) @(negedge clk);
    #2;
    check("stallBusy", FetchBusy, 0);
    check("stallInstr", InstrD, 32'hC);
    check("stallValid", ValidD, 1);
    StallF = 0; StallD = 0; memOn = 0;
    @(negedge clk);
    check("stallRelease", q.size(), 0);
    // Redirect while waiting on a slow response; the late 0xDEAD must be dropped.
    lat = 3; memOn = 1;
    for (int k = 0; k < 10 && !acceptFlag; k++) @(negedge clk);
    check("acceptSeen", acceptFlag, 1);
    PCSrcE = 1; PCTargetE = 32'h100; FlushD = 1; forceDead = 1;
    q.push_back('{pc: 32'h100, instr: 32'h100});
    @(negedge clk);
    PCSrcE = 0; FlushD = 0; lat = 0;
    #2;
    check("dropReq", imem_req, 0);
    for (int k = 0; k < 10 && !imem_req; k++) @(negedge clk);
    check("redirReq", imem_req, 1);
    check("redirAddr", imem_addr, 32'h100);
    drain(20);
    // Flush and stall together: flush wins.
    FlushD = 1; StallD = 1;
    @(negedge clk); #2;
    check("flushValid", ValidD, 0);
    check("flushInstr", InstrD, 32'h13);
    check("flushPCD", PCD, 32'h100);
    FlushD = 0; StallD = 0;
    // Slow memory: not ready, then 3-cycle response; busy and bubbles throughout.
`ifdef FETCH_STATS_EN
    base = statBubble;
`endif
    lat = 2;
    q.push_back('{pc: 32'h104, instr: 32'h104});
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #2;
      check("slowBusy", FetchBusy, 1);
      check("slowValid", ValidD, 0);
      if (i == 3) memOn = 1;
    end
    @(negedge clk); #2;
    check("slowAvail", FetchBusy, 0);
`ifdef FETCH_STATS_EN
    check("bubbleCnt", statBubble - base, 8);
    check("redirectCnt", statRedirect, 1);
`endif
    drain(10);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
